// File: rtl/fdiv_out_stage.sv
// Registered output stage for the fdiv block: classifies each result, buffers it
// in a 2-entry skid buffer, and keeps sticky exception flags plus an op counter.
module fdiv_out_stage #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [N-1:0]     in_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_res,
    output logic [4:0]       out_flags,
    output logic [4:0]       sticky_flags,
    output logic [CNT_W-1:0] op_count,
    input  logic             flag_clr
);
    // state   | meaning
    // S_EMPTY | main entry invalid, nothing presented downstream
    // S_ONE   | main valid, skid empty
    // S_FULL  | main and skid valid, upstream stalled
    localparam int EW = (N == 64) ? 11 : 8;
    localparam int MW = N - 1 - EW;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]   state, state_nxt;
    logic [N-1:0] main_res, skid_res;
    logic [4:0]   main_flags, skid_flags;
    logic [4:0]   in_flags;
    logic         ready_q;
    logic         in_xfer, out_xfer;
    logic         load_main, load_skid, main_from_skid;

    function automatic logic [4:0] classify(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [N-1:0] res);
        logic [EW-1:0] ea, eb, er;
        logic [MW-1:0] mr;
        logic          nan, inf, zero, dbz, ovf;
        ea   = a[N-2 -: EW];
        eb   = b[N-2 -: EW];
        er   = res[N-2 -: EW];
        mr   = res[MW-1:0];
        nan  = (&er) & (|mr);
        inf  = (&er) & ~(|mr);
        zero = ~(|res[N-2:0]);
        dbz  = ~(|b[N-2:0]) & (|a[N-2:0]) & ~(&ea);
        ovf  = inf & ~(&ea) & ~(&eb) & (|b[N-2:0]);
        return {ovf, dbz, zero, inf, nan};
    endfunction

    assign in_flags  = classify(in_a, in_b, in_res);
    assign out_valid = (state != S_EMPTY);
    assign in_ready  = ready_q;
    assign in_xfer   = in_valid & ready_q;
    assign out_xfer  = out_valid & out_ready;
    assign out_res   = main_res;
    assign out_flags = main_flags;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            S_EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = S_EMPTY;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (out_xfer) begin
                    main_from_skid = 1'b1;
                    state_nxt      = S_ONE;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_EMPTY;
            ready_q    <= 1'b0;
            main_res   <= '0;
            main_flags <= '0;
            skid_res   <= '0;
            skid_flags <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != S_FULL);
            if (load_main) begin
                main_res   <= in_res;
                main_flags <= in_flags;
            end else if (main_from_skid) begin
                main_res   <= skid_res;
                main_flags <= skid_flags;
            end
            if (load_skid) begin
                skid_res   <= in_res;
                skid_flags <= in_flags;
            end
        end
    end

    // A clear coinciding with a transfer wipes the old status before the word is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= '0;
            op_count     <= '0;
        end else if (out_xfer) begin
            sticky_flags <= (flag_clr ? 5'd0 : sticky_flags) | main_flags;
            if (flag_clr)
                op_count <= CNT_W'(1);
            else if (op_count != {CNT_W{1'b1}})
                op_count <= op_count + CNT_W'(1);
        end else if (flag_clr) begin
            sticky_flags <= '0;
            op_count     <= '0;
        end
    end

endmodule

// File: tb/tb_fdiv_out_stage.sv
// Self-checking bench for fdiv_out_stage: directed scenarios plus random
// valid/ready traffic checked against a queue-based reference model.
module tb_fdiv_out_stage;
    localparam int N     = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic [N-1:0]     in_res = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_res;
    logic [4:0]       out_flags;
    logic [4:0]       sticky_flags;
    logic [CNT_W-1:0] op_count;
    logic             flag_clr = 1'b0;

    fdiv_out_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_res(in_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .op_count(op_count),
        .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
    } word_t;

    word_t       q[$];
    logic [4:0]  m_sticky = '0;
    logic [15:0] m_cnt = '0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [4:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] r);
        int unsigned ea, eb, er, mr, amag, bmag, rmag;
        logic nan, inf, zero, dbz, ovf;
        ea   = (a >> 23) & 32'hFF;
        eb   = (b >> 23) & 32'hFF;
        er   = (r >> 23) & 32'hFF;
        mr   = r & 32'h007F_FFFF;
        amag = a & 32'h7FFF_FFFF;
        bmag = b & 32'h7FFF_FFFF;
        rmag = r & 32'h7FFF_FFFF;
        nan  = (er == 255) && (mr != 0);
        inf  = (er == 255) && (mr == 0);
        zero = (rmag == 0);
        dbz  = (bmag == 0) && (amag != 0) && (ea != 255);
        ovf  = inf && (ea != 255) && (eb != 255) && (bmag != 0);
        return {ovf, dbz, zero, inf, nan};
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'hFF80_0000;
            4: return 32'h7FC0_0001;
            5: return 32'h7F7F_FFFF;
            6: return 32'h0080_0000;
            default: return $urandom;
        endcase
    endfunction

    // One clock: check outputs at negedge against the model, then advance the model.
    task automatic step(output bit in_x);
        bit    out_x, clr;
        word_t w, nw;
        @(negedge clk);
        checks++;
        if (out_valid !== (q.size() > 0)) begin
            errors++; $display("FAIL out_valid got %b exp %b", out_valid, q.size() > 0);
        end
        checks++;
        if (in_ready !== (q.size() < 2)) begin
            errors++; $display("FAIL in_ready got %b exp %b", in_ready, q.size() < 2);
        end
        if (q.size() > 0) begin
            checks++;
            if (out_res !== q[0].res) begin
                errors++; $display("FAIL out_res got %h exp %h", out_res, q[0].res);
            end
            checks++;
            if (out_flags !== q[0].flags) begin
                errors++; $display("FAIL out_flags got %b exp %b", out_flags, q[0].flags);
            end
        end
        checks++;
        if (sticky_flags !== m_sticky) begin
            errors++; $display("FAIL sticky_flags got %b exp %b", sticky_flags, m_sticky);
        end
        checks++;
        if (op_count !== m_cnt) begin
            errors++; $display("FAIL op_count got %h exp %h", op_count, m_cnt);
        end
        in_x  = in_valid && (q.size() < 2);
        out_x = (q.size() > 0) && out_ready;
        clr   = flag_clr;
        nw.res   = in_res;
        nw.flags = ref_flags(in_a, in_b, in_res);
        @(posedge clk);
        if (out_x) begin
            w = q.pop_front();
            m_sticky = (clr ? 5'd0 : m_sticky) | w.flags;
            m_cnt    = clr ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
        end else if (clr) begin
            m_sticky = '0;
            m_cnt    = '0;
        end
        if (in_x) q.push_back(nw);
        #1;
    endtask

    task automatic clear_status();
        bit x;
        flag_clr = 1'b1;
        step(x);
        flag_clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, in_ready, out_res, out_flags, sticky_flags, op_count} !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%b r=%b res=%h f=%b s=%b c=%h exp all zero",
                     out_valid, in_ready, out_res, out_flags, sticky_flags, op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge got %b exp 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_edge got %b exp 1", in_ready);
        end
    endtask

    task automatic test_basic();
        bit x;
        in_valid = 1'b1; in_a = 32'h40C0_0000; in_b = 32'h4000_0000; in_res = 32'h4040_0000;
        out_ready = 1'b1;
        step(x);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_res, out_flags} !== {1'b1, 32'h4040_0000, 5'b00000}) begin
            errors++;
            $display("FAIL basic_out got v=%b res=%h f=%b exp 1 40400000 00000",
                     out_valid, out_res, out_flags);
        end
        step(x);
        checks++;
        if (op_count !== 16'd1) begin
            errors++; $display("FAIL basic_count got %h exp 0001", op_count);
        end
    endtask

    task automatic test_flags();
        logic [31:0] va[4] = '{32'h3F80_0000, 32'h7F80_0000, 32'h7F00_0000, 32'h3F80_0000};
        logic [31:0] vb[4] = '{32'h0000_0000, 32'h7F80_0000, 32'h0080_0000, 32'h4000_0000};
        logic [31:0] vr[4] = '{32'h7F80_0000, 32'h7FFF_FFFF, 32'h7F80_0000, 32'h0000_0000};
        logic [4:0]  vf[4] = '{5'b01010, 5'b00001, 5'b10010, 5'b00100};
        bit x;
        out_ready = 1'b1;
        clear_status();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_res = vr[i];
            step(x);
            in_valid = 1'b0;
            checks++;
            if (out_flags !== vf[i]) begin
                errors++; $display("FAIL flags_%0d got %b exp %b", i, out_flags, vf[i]);
            end
            step(x);
            if (i == 0) begin
                checks++;
                if (sticky_flags !== 5'b01010) begin
                    errors++; $display("FAIL sticky_first got %b exp 01010", sticky_flags);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[3];
        bit x;
        int k;
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        clear_status();
        out_ready = 1'b0;
        in_a = 32'h3F80_0000; in_b = 32'h3F80_0000;
        in_valid = 1'b1; in_res = w[0]; step(x);
        in_res = w[1]; step(x);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_ready got %b exp 0", in_ready);
        end
        in_res = w[2];
        for (int i = 0; i < 3; i++) begin
            step(x);
            checks++;
            if (out_res !== w[0]) begin
                errors++; $display("FAIL b2b_hold got %h exp %h", out_res, w[0]);
            end
        end
        out_ready = 1'b1;
        k = 0;
        do begin
            step(x);
            k++;
        end while (!x && k < 10);
        checks++;
        if (!x) begin
            errors++; $display("FAIL b2b_w3_accept got 0 exp 1");
        end
        in_valid = 1'b0;
        step(x);
        checks++;
        if (op_count !== 16'd3) begin
            errors++; $display("FAIL b2b_count got %h exp 0003", op_count);
        end
        step(x);
    endtask

    task automatic test_saturate();
        bit x;
        int k;
        clear_status();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        k = 0;
        while (m_cnt != 16'hFFFF && k < 70000) begin
            in_a = rand_word(); in_b = rand_word(); in_res = rand_word();
            step(x);
            k++;
        end
        checks++;
        if (m_cnt != 16'hFFFF) begin
            errors++; $display("FAIL sat_reach got %h exp ffff", m_cnt);
        end
        step(x);
        checks++;
        if (op_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold got %h exp ffff", op_count);
        end
        in_valid = 1'b0;
        step(x);
        step(x);
        in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_res = 32'h0;
        step(x);
        in_valid = 1'b0;
        flag_clr = 1'b1;
        step(x);
        flag_clr = 1'b0;
        checks++;
        if ({sticky_flags, op_count} !== {5'b00100, 16'd1}) begin
            errors++;
            $display("FAIL clr_with_xfer got s=%b c=%h exp 00100 0001", sticky_flags, op_count);
        end
    endtask

    task automatic test_reset_mid();
        bit x;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 32'h3F80_0000; in_b = 32'h0; in_res = 32'h7F80_0000;
        step(x);
        in_res = 32'h7F80_0000;
        step(x);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, sticky_flags, op_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid got v=%b r=%b s=%b c=%h exp all zero",
                     out_valid, in_ready, sticky_flags, op_count);
        end
        q.delete();
        m_sticky = '0;
        m_cnt    = '0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(x);
        in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h3F80_0000; in_res = 32'h4000_0000;
        step(x);
        in_valid = 1'b0;
        step(x);
        step(x);
    endtask

    task automatic run_stream(input int n, input int pv, input int pr);
        bit took, x;
        took = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (took) begin
                in_valid = ($urandom_range(0, 99) < pv);
                in_a = rand_word(); in_b = rand_word(); in_res = rand_word();
            end
            out_ready = ($urandom_range(0, 99) < pr);
            flag_clr  = ($urandom_range(0, 99) < 3);
            step(x);
            took = x || !in_valid;
        end
        in_valid = 1'b0;
        flag_clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(x);
    endtask

    task automatic test_random();
        run_stream(1500, 60, 60);
        run_stream(500, 90, 90);
        run_stream(500, 90, 20);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fdiv_out_stage.md
Name: fdiv_out_stage

Overview:
- Registered output stage directly downstream of the combinational fdiv block.
- Captures each fdiv result together with its operands and classifies the result into per-result exception flags.
- Presents result and flags on a valid/ready interface through a 2-entry skid buffer.
- Keeps sticky exception flags and a saturating operation counter for status readout.

Parameters:
N, 32, float width; 32 (exp 8 bits, man 23 bits) or 64 (exp 11 bits, man 52 bits); field widths derived internally from N
CNT_W, 16, width of operation counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  stage can accept a word
in_a  input  N  dividend as presented to fdiv
in_b  input  N  divisor as presented to fdiv
in_res  input  N  fdiv result for in_a/in_b
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts the output word
out_res  output  N  registered result
out_flags  output  5  per-result flags: [0] nan, [1] inf, [2] zero, [3] dbz, [4] ovf
sticky_flags  output  5  OR of out_flags over all transferred words since the last clear
op_count  output  CNT_W  number of output transfers, saturating
flag_clr  input  1  synchronous clear of sticky_flags and op_count

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, in_ready=0, out_res=0, out_flags=0, sticky_flags=0, op_count=0.
  - Both buffer entries are invalidated.
  - in_ready rises to 1 on the first clk edge after rst_n deasserts.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready.
  - out_res and out_flags remain stable while out_valid=1 and out_ready=0.
- Classification, computed from the input word at capture time. Fields: E = exponent field, M = mantissa field.
  - nan = (E(res) all ones) & (M(res) != 0)
  - inf = (E(res) all ones) & (M(res) == 0)
  - zero = (res[N-2:0] == 0)
  - dbz = (b[N-2:0] == 0) & (a[N-2:0] != 0) & (E(a) not all ones)
  - ovf = inf & (E(a) not all ones) & (E(b) not all ones) & (b[N-2:0] != 0)
- Buffer: main entry drives the outputs; the skid entry is loaded only when main is held.
  - EMPTY (main invalid): on input transfer, load main and go to ONE. out_valid=0, in_ready=1.
  - ONE (main valid, skid empty), out_valid=1, in_ready=1:
    - Input and output transfer together: reload main, stay in ONE.
    - Output transfer only: go to EMPTY.
    - Input transfer only: load skid, go to FULL.
  - FULL, out_valid=1, in_ready=0: on output transfer, move skid into main and go to ONE.
  - in_ready is a registered signal, equal to "skid empty" after the next edge.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Throughput is 1 word/cycle with out_ready held high.
  - Word order is preserved; no word is lost or duplicated under any in_valid/out_ready pattern.
- sticky_flags: on each output transfer, sticky |= out_flags.
- op_count: on each output transfer, increments by 1; saturates at all ones.
- flag_clr:
  - Alone: sticky_flags=0 and op_count=0 next cycle.
  - Same cycle as an output transfer: clear takes effect first, so sticky_flags = out_flags of that word and op_count=1.
- Reset mid-operation: all buffered words are discarded; no out_valid pulse appears after reset.

Test Plan:
- N=32: in_a=0x40C00000, in_b=0x40000000, in_res=0x40400000, out_ready=1 -> next cycle out_valid=1, out_res=0x40400000, out_flags=0, then op_count=1.
- in_a=0x3F800000, in_b=0x00000000, in_res=0x7F800000 -> out_flags=5'b01010 (inf, dbz), sticky_flags=5'b01010 after transfer.
- in_a=0x7F800000, in_b=0x7F800000, in_res=0x7FFFFFFF -> out_flags=5'b00001; in_a=0x7F000000, in_b=0x00800000, in_res=0x7F800000 -> out_flags=5'b10010 (inf, ovf).
- out_ready=0, three words W1/W2/W3 offered back-to-back -> W1 and W2 accepted, in_ready=0 from the cycle after W2 accepted, W3 held upstream, out_res=W1 stable; raise out_ready -> W1, W2, W3 delivered in consecutive cycles, op_count=3.
- op_count preloaded to 0xFFFF via 65535 transfers, one further transfer -> stays 0xFFFF; then flag_clr together with a zero-result transfer (in_res=0) -> sticky_flags=5'b00100, op_count=1.
- Buffer FULL, pull rst_n low mid-cycle -> out_valid=0, in_ready=0, sticky_flags=0, op_count=0 immediately; after release, out_valid stays 0 until a new input transfer.
